// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// Instruction-fetch front end: owns the PC, handshakes with instruction memory,
// parks one word across an ID freeze and turns taken branches into redirect + flush.
//
// state     | meaning
// IDLE      | post-reset cycle, no request
// FETCH     | request to pc outstanding
// DISCARD   | request outstanding but made stale by a branch; pc goes to redir on ack
// HOLD      | fetched word parked in hold_pc/hold_instr while ID is frozen
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid,
  output logic        flush
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DISCARD = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] redir_q;
  logic [31:0] hold_pc_q;
  logic [31:0] hold_instr_q;
  logic [31:0] pc_out_q;
  logic [31:0] instr_out_q;
  logic        valid_q;
  logic        flush_q;

  logic        slot_free;
  logic [31:0] pc_inc;

  assign slot_free = !valid_q || !freeze;
  assign pc_inc    = pc_q + 32'd4;

  assign imem_req  = (state_q == S_FETCH) || (state_q == S_DISCARD);
  assign imem_addr = pc_q;
  assign pc_out    = pc_out_q;
  assign instr_out = instr_out_q;
  assign valid     = valid_q;
  assign flush     = flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      redir_q      <= '0;
      hold_pc_q    <= '0;
      hold_instr_q <= NOP;
      pc_out_q     <= '0;
      instr_out_q  <= NOP;
      valid_q      <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      flush_q <= branch_taken;
      if (branch_taken) begin
        // Branch overrides freeze and any parked word.
        valid_q      <= 1'b0;
        pc_out_q     <= '0;
        instr_out_q  <= NOP;
        hold_pc_q    <= '0;
        hold_instr_q <= NOP;
        case (state_q)
          S_FETCH, S_DISCARD: begin
            if (imem_ack) begin
              pc_q    <= branch_target;
              state_q <= S_FETCH;
            end else begin
              // Address must stay put until the pending ack, so park the target.
              redir_q <= branch_target;
              state_q <= S_DISCARD;
            end
          end
          default: begin
            pc_q    <= branch_target;
            state_q <= S_FETCH;
          end
        endcase
      end else begin
        case (state_q)
          S_IDLE: state_q <= S_FETCH;
          S_FETCH: begin
            if (imem_ack) begin
              pc_q <= pc_inc;
              if (slot_free) begin
                valid_q     <= 1'b1;
                pc_out_q    <= pc_inc;
                instr_out_q <= imem_rdata;
              end else begin
                hold_pc_q    <= pc_inc;
                hold_instr_q <= imem_rdata;
                state_q      <= S_HOLD;
              end
            end else if (slot_free) begin
              valid_q     <= 1'b0;
              pc_out_q    <= '0;
              instr_out_q <= NOP;
            end
          end
          S_DISCARD: begin
            if (imem_ack) begin
              pc_q        <= redir_q;
              state_q     <= S_FETCH;
              valid_q     <= 1'b0;
              pc_out_q    <= '0;
              instr_out_q <= NOP;
            end
          end
          S_HOLD: begin
            if (!freeze) begin
              valid_q     <= 1'b1;
              pc_out_q    <= hold_pc_q;
              instr_out_q <= hold_instr_q;
              state_q     <= S_FETCH;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// Directed bench for fetch_unit: a queue-based behavioural model checked every cycle,
// plus literal expectations at the scenario milestones.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken;
  logic [31:0] branch_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_out, instr_out;
  logic        valid, flush;

  logic        req2, ack2, valid2, flush2;
  logic [31:0] addr2, rdata2, pc_out2, instr2;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  int lat = 0;
  int wait_cnt = 0;
  bit mem_manual = 1'b0;
  bit man_ack = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_out(pc_out),
    .instr_out(instr_out), .valid(valid), .flush(flush)
  );

  // Second instance checks the wrapping reset PC against a zero-wait memory.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .pc_out(pc_out2),
    .instr_out(instr2), .valid(valid2), .flush(flush2)
  );
  assign ack2   = req2;
  assign rdata2 = mem_word(addr2);

  // Memory for the main DUT: ack after `lat` waiting cycles, or manual override.
  initial imem_ack = 1'b0;
  always @(negedge clk) begin
    #2;
    imem_ack   = mem_manual ? man_ack : (imem_req && (wait_cnt >= lat));
    imem_rdata = mem_word(imem_addr);
  end
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pending fetch, stale flag and a one-deep parked-word queue.
  logic [31:0] m_pc = 32'h0, m_redir = 32'h0, m_opc = 32'h0, m_oinstr = NOP;
  bit          m_valid = 1'b0, m_flush = 1'b0, m_active = 1'b0, m_stale = 1'b0;
  logic [63:0] m_buf[$];

  always @(posedge clk) begin : model
    bit          req, acc, slot;
    logic [63:0] e;
    if (rst) begin
      m_pc = 32'h0; m_valid = 0; m_opc = 32'h0; m_oinstr = NOP;
      m_flush = 0; m_active = 0; m_stale = 0; m_buf.delete();
    end else begin
      req  = m_active && (m_buf.size() == 0);
      acc  = req && (imem_ack === 1'b1);
      slot = !m_valid || !freeze;
      m_flush = branch_taken;
      if (branch_taken) begin
        m_valid = 0; m_opc = 32'h0; m_oinstr = NOP; m_buf.delete();
        if (req && !acc) begin
          m_redir = branch_target;
          m_stale = 1;
        end else begin
          m_pc    = branch_target;
          m_stale = 0;
        end
        m_active = 1;
      end else if (!m_active) begin
        m_active = 1;
      end else if (m_buf.size() != 0) begin
        if (!freeze) begin
          e = m_buf.pop_front();
          m_valid = 1; m_opc = e[63:32]; m_oinstr = e[31:0];
        end
      end else if (m_stale) begin
        if (acc) begin
          m_pc = m_redir;
          m_stale = 0;
        end
      end else if (acc) begin
        if (slot) begin
          m_valid = 1; m_opc = m_pc + 32'd4; m_oinstr = mem_word(m_pc);
        end else begin
          m_buf.push_back({m_pc + 32'd4, mem_word(m_pc)});
        end
        m_pc = m_pc + 32'd4;
      end else if (slot) begin
        m_valid = 0; m_opc = 32'h0; m_oinstr = NOP;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("valid", {31'b0, valid}, {31'b0, m_valid});
      cmp("pc_out", pc_out, m_opc);
      cmp("instr_out", instr_out, m_oinstr);
      cmp("flush", {31'b0, flush}, {31'b0, m_flush});
      cmp("imem_req", {31'b0, imem_req}, {31'b0, (m_active && (m_buf.size() == 0))});
      cmp("imem_addr", imem_addr, m_pc);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    repeat (2) @(posedge clk);
    step();
    chk_en = 1'b1;
    cmp("rst_valid", {31'b0, valid}, 32'h0);
    cmp("rst_instr", instr_out, NOP);
    cmp("rst_req", {31'b0, imem_req}, 32'h0);
    rst = 1'b0;

    step();
    cmp("first_req", {31'b0, imem_req}, 32'h1);
    cmp("first_valid", {31'b0, valid}, 32'h0);
    cmp("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    step();
    cmp("seq_pc0", pc_out, 32'h4);
    cmp("seq_in0", instr_out, 32'hC0DE_0000);
    cmp("wrap_pc_out", pc_out2, 32'h0);
    cmp("wrap_instr", instr2, 32'h3F21_FFFC);
    cmp("wrap_second_addr", addr2, 32'h0);
    step();
    cmp("seq_pc1", pc_out, 32'h8);
    cmp("seq_in1", instr_out, 32'hC0DE_0004);
    cmp("wrap_pc_out2", pc_out2, 32'h4);

    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      cmp("hold_pc", pc_out, 32'h8);
      cmp("hold_noreq", {31'b0, imem_req}, 32'h0);
    end
    freeze = 1'b0;
    step();
    cmp("unhold_pc", pc_out, 32'hC);
    cmp("unhold_instr", instr_out, 32'hC0DE_0008);
    cmp("resume_addr", imem_addr, 32'hC);
    cmp("model_pin_pc", m_opc, 32'hC);
    step();
    cmp("resume_pc", pc_out, 32'h10);

    branch_taken = 1'b1; branch_target = 32'h100;
    step();
    branch_taken = 1'b0;
    cmp("br_flush", {31'b0, flush}, 32'h1);
    cmp("br_valid", {31'b0, valid}, 32'h0);
    cmp("br_addr", imem_addr, 32'h100);
    step();
    cmp("br_pc", pc_out, 32'h104);
    cmp("br_flush_off", {31'b0, flush}, 32'h0);

    branch_taken = 1'b1; branch_target = 32'h10;
    step();
    branch_taken = 1'b0; lat = 2;
    cmp("slow_addr0", imem_addr, 32'h10);
    step();
    cmp("slow_addr1", imem_addr, 32'h10);
    branch_taken = 1'b1; branch_target = 32'h200;
    step();
    branch_taken = 1'b0;
    cmp("disc_addr", imem_addr, 32'h10);
    cmp("disc_flush", {31'b0, flush}, 32'h1);
    step();
    cmp("disc_redir", imem_addr, 32'h200);
    cmp("disc_valid", {31'b0, valid}, 32'h0);
    step();
    step();
    cmp("disc_still_bubble", {31'b0, valid}, 32'h0);
    step();
    cmp("disc_pc", pc_out, 32'h204);
    cmp("disc_instr", instr_out, 32'hC0DE_0200);

    lat = 0; freeze = 1'b1;
    step();
    cmp("hb_hold_pc", pc_out, 32'h204);
    cmp("hb_noreq", {31'b0, imem_req}, 32'h0);
    branch_taken = 1'b1; branch_target = 32'h300;
    step();
    branch_taken = 1'b0;
    cmp("hb_flush", {31'b0, flush}, 32'h1);
    cmp("hb_valid", {31'b0, valid}, 32'h0);
    cmp("hb_addr", imem_addr, 32'h300);
    step();
    cmp("hb_pc", pc_out, 32'h304);
    freeze = 1'b0;
    step();
    cmp("hb_pc_next", pc_out, 32'h308);

    mem_manual = 1'b1; man_ack = 1'b0;
    step();
    cmp("mw_addr", imem_addr, 32'h308);
    rst = 1'b1;
    step();
    cmp("mw_rst_valid", {31'b0, valid}, 32'h0);
    cmp("mw_rst_pc", pc_out, 32'h0);
    cmp("mw_rst_req", {31'b0, imem_req}, 32'h0);
    cmp("mw_rst_addr", imem_addr, 32'h0);
    rst = 1'b0; man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    cmp("late_ack_valid", {31'b0, valid}, 32'h0);
    cmp("late_ack_addr", imem_addr, 32'h0);
    step();
    cmp("late_ack_valid2", {31'b0, valid}, 32'h0);
    mem_manual = 1'b0; lat = 0;
    step();
    cmp("restart_pc", pc_out, 32'h4);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
